// File: rtl/dshot_pkg.sv
// DShot shared definitions: timing derivation, frame width, CRC and FSM state encoding.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dshot_pkg;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BIT_HI = 2'd1,
        ST_BIT_LO = 2'd2,
        ST_GAP    = 2'd3
    } dshot_state_e;

    // Clock cycles per DShot bit period (integer divide).
    function automatic int cyc_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // High time of a '1' bit: three quarters of the bit period.
    function automatic int t1h_cyc(input int cyc);
        return (cyc * 3) / 4;
    endfunction

    // High time of a '0' bit: three eighths of the bit period.
    function automatic int t0h_cyc(input int cyc);
        return (cyc * 3) / 8;
    endfunction

    // 4-bit checksum over the 12-bit payload {throttle, telem}.
    function automatic logic [3:0] dshot_crc(input logic [11:0] v12);
        return v12[11:8] ^ v12[7:4] ^ v12[3:0];
    endfunction

endpackage

// File: rtl/dshot_frame_builder.sv
// Builds the 16-bit DShot frame {throttle, telem, crc} from the raw command.
// Latency: combinational, zero cycles.
// Backpressure: none; output simply follows the inputs.
module dshot_frame_builder
    import dshot_pkg::*;
(
    input  logic [10:0] throttle_i,
    input  logic        telem_i,
    output logic [15:0] frame_o
);

    logic [11:0] v12;

    // Payload is throttle followed by the telemetry request, checksum appended.
    always_comb begin
        v12     = {throttle_i, telem_i};
        frame_o = {v12, dshot_crc(v12)};
    end

endmodule

// File: rtl/dshot_tx_encoder.sv
// DShot transmitter: latches a frame on send&&ready and serialises it MSB-first with a trailing low gap.
// Latency: line rises one clock after the accept edge; frame plus gap lasts (16+GAP_BITS)*CYC_BIT cycles.
// Backpressure: ready low from accept until the gap ends; send while busy is dropped, never queued.
module dshot_tx_encoder
    import dshot_pkg::*;
#(
    parameter int CLK_HZ   = 16000000,
    parameter int BIT_RATE = 150000,
    parameter int GAP_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] throttle_i,
    input  logic        telem_i,
    input  logic        send_i,
    output logic        ready_o,
    output logic        dshot_out_o,
    output logic        frame_done_o
);

    localparam int CYC_BIT = cyc_bit(CLK_HZ, BIT_RATE);
    localparam int T1H     = t1h_cyc(CYC_BIT);
    localparam int T0H     = t0h_cyc(CYC_BIT);
    localparam int GAP_CYC = GAP_BITS * CYC_BIT;
    localparam int CNT_W   = $clog2(GAP_CYC + 1);

    // Terminal counts (phase length minus one) for each timed phase.
    localparam logic [CNT_W-1:0] T1H_LAST = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] T0H_LAST = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] T1L_LAST = CNT_W'(CYC_BIT - T1H - 1);
    localparam logic [CNT_W-1:0] T0L_LAST = CNT_W'(CYC_BIT - T0H - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    dshot_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       shreg_q, shreg_d;
    logic [3:0]        idx_q, idx_d;
    logic              dshot_q;
    logic [15:0]       frame_w;
    logic [CNT_W-1:0]  hi_last;
    logic [CNT_W-1:0]  lo_last;

    dshot_frame_builder u_builder (
        .throttle_i (throttle_i),
        .telem_i    (telem_i),
        .frame_o    (frame_w)
    );

    // Phase lengths depend on the bit currently at the top of the shifter.
    assign hi_last = shreg_q[15] ? T1H_LAST : T0H_LAST;
    assign lo_last = shreg_q[15] ? T1L_LAST : T0L_LAST;

    assign ready_o      = (state_q == ST_IDLE);
    assign frame_done_o = (state_q == ST_GAP) && (cnt_q == GAP_LAST);
    assign dshot_out_o  = dshot_q;

    // Next-state, counter, shifter and bit-index logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (send_i) begin
                    state_d = ST_BIT_HI;
                    cnt_d   = '0;
                    shreg_d = frame_w;
                    idx_d   = 4'(FRAME_BITS - 1);
                end
            end
            ST_BIT_HI: begin
                if (cnt_q == hi_last) begin
                    state_d = ST_BIT_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BIT_LO: begin
                if (cnt_q == lo_last) begin
                    cnt_d   = '0;
                    shreg_d = {shreg_q[14:0], 1'b0};
                    if (idx_q == 4'd0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_BIT_HI;
                        idx_d   = idx_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; the line is a registered copy of "in high phase", so it trails state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            dshot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            dshot_q <= (state_q == ST_BIT_HI);
        end
    end

endmodule
